// File: rtl/dmem_responder.sv
// Fixed-latency word-organised SRAM responder for a CPU memory port.
// One request is served at a time: IDLE -> WAIT (optional) -> RESP -> IDLE.
module dmem_responder #(
  parameter int    ADDR_W    = 8,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                resp_q, resp_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                enter_resp;
  logic                mem_we;
  logic [31:0]         mem_array [DEPTH];

  // Byte-offset bits and bits above the word index are aliased away.
  logic unused_addr;
  assign unused_addr = ^{mem_address[31:ADDR_W+2], mem_address[1:0]};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    enter_resp = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = mem_address[ADDR_W+1:2];
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          rd_d    = mem_read;
          wr_d    = mem_write;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The *_d request fields equal the live inputs on a LATENCY==1 sampling edge
    // and the latched values otherwise, so they serve as the commit source.
    resp_d  = enter_resp;
    err_d   = enter_resp && rd_d && wr_d;
    rdata_d = rdata_q;
    if (enter_resp) begin
      rdata_d = (rd_d && !wr_d) ? mem_array[idx_d] : 32'h0;
    end
  end

  assign mem_we = enter_resp && wr_d && !rst;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; contents start undefined.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) begin
          mem_array[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LATENCY 2, 3 and 1
// share clock and reset; index 0/1/2 of the stimulus arrays selects the instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_v = '0;
  logic [2:0]  wr_v = '0;
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic [3:0]  be_v    [3];
  wire  [2:0]  resp_v;
  wire  [2:0]  err_v;
  wire  [31:0] rdata_v [3];

  int          total = 0;
  int          bad   = 0;
  int          lat;
  logic [31:0] got;
  logic        got_err;
  logic [11:0] mask;
  int          pulses;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .mem_read(rd_v[0]), .mem_write(wr_v[0]),
    .mem_address(addr_v[0]), .mem_wdata(wdata_v[0]), .mem_byte_enable(be_v[0]),
    .mem_rdata(rdata_v[0]), .mem_resp(resp_v[0]), .mem_err(err_v[0])
  );

  dmem_responder #(.ADDR_W(8), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .mem_read(rd_v[1]), .mem_write(wr_v[1]),
    .mem_address(addr_v[1]), .mem_wdata(wdata_v[1]), .mem_byte_enable(be_v[1]),
    .mem_rdata(rdata_v[1]), .mem_resp(resp_v[1]), .mem_err(err_v[1])
  );

  dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_read(rd_v[2]), .mem_write(wr_v[2]),
    .mem_address(addr_v[2]), .mem_wdata(wdata_v[2]), .mem_byte_enable(be_v[2]),
    .mem_rdata(rdata_v[2]), .mem_resp(resp_v[2]), .mem_err(err_v[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, count edges (sampling edge = 1) until mem_resp, then drop it.
  task automatic req(input int k, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be);
    @(negedge clk);
    rd_v[k]    = rd;
    wr_v[k]    = wr;
    addr_v[k]  = addr;
    wdata_v[k] = wdata;
    be_v[k]    = be;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (resp_v[k]) begin
        lat = n;
        break;
      end
    end
    got     = rdata_v[k];
    got_err = err_v[k];
    rd_v[k] = 1'b0;
    wr_v[k] = 1'b0;
    @(posedge clk);
    #1;
    check("pulse_width", {31'b0, resp_v[k]}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      addr_v[k]  = 32'h0;
      wdata_v[k] = 32'h0;
      be_v[k]    = 4'h0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_resp", {29'b0, resp_v}, 32'd0);
    check("rst_err", {29'b0, err_v}, 32'd0);
    check("rst_rdata", rdata_v[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full-word write then read, LATENCY=2
    req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", {31'b0, got_err}, 32'd0);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_data", got, 32'hDEADBEEF);
    check("lw_hold", rdata_v[0], 32'hDEADBEEF);

    // Byte-lane write and empty byte enable
    req(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'b1111);
    req(0, 1'b0, 1'b1, 32'h21, 32'h0000AA00, 4'b0010);
    req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'b0000);
    check("sb_merge", got, 32'h1122AA44);
    req(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    check("be0_lat", 32'(lat), 32'd2);
    req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'b0000);
    check("be0_nochange", got, 32'h1122AA44);

    // Read held high for 12 edges: pulses on edges 1,4,7,10 only
    @(negedge clk);
    rd_v[0]   = 1'b1;
    addr_v[0] = 32'h10;
    mask = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      mask[i] = resp_v[0];
    end
    rd_v[0] = 1'b0;
    check("held_pattern", {20'b0, mask}, 32'h0000_0492);
    check("held_data", rdata_v[0], 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Address aliasing and ignored byte offset
    req(0, 1'b0, 1'b1, 32'h400, 32'h00000055, 4'b1111);
    req(0, 1'b1, 1'b0, 32'h000, 32'h0, 4'b0000);
    check("wrap_read", got, 32'h00000055);
    req(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'b0000);
    check("offset_read", got, 32'hDEADBEEF);
    req(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'b0000);
    check("high_alias", got, 32'hDEADBEEF);

    // Read and write together
    req(0, 1'b1, 1'b1, 32'h30, 32'h12345678, 4'b1111);
    check("rw_lat", 32'(lat), 32'd2);
    check("rw_err", {31'b0, got_err}, 32'd1);
    check("rw_rdata", got, 32'h0);
    req(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'b0000);
    check("rw_readback", got, 32'h12345678);
    check("rw_err_clear", {31'b0, got_err}, 32'd0);

    // LATENCY=3: reset during WAIT aborts the write
    req(1, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'b1111);
    check("l3_lat", 32'(lat), 32'd3);
    @(negedge clk);
    wr_v[1]    = 1'b1;
    addr_v[1]  = 32'h40;
    wdata_v[1] = 32'h0;
    be_v[1]    = 4'b1111;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_resp_now", {31'b0, resp_v[1]}, 32'd0);
    @(posedge clk);
    #1;
    wr_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (resp_v[1]) pulses++;
    end
    check("abort_no_resp", 32'(pulses), 32'd0);
    req(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'b0000);
    check("abort_idle_lat", 32'(lat), 32'd3);
    check("abort_old_word", got, 32'hA5A5A5A5);

    // LATENCY=1
    req(2, 1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 4'b1111);
    check("l1_wr_lat", 32'(lat), 32'd1);
    req(2, 1'b1, 1'b0, 32'h44, 32'h0, 4'b0000);
    check("l1_rd_lat", 32'(lat), 32'd1);
    check("l1_rd_data", got, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
